can_bit_destuffer: RTL and testbench

// - Upstream stage of the CAN frame-error block. Removes stuff bits from the sampled RX bit stream.
// - Detects stuff violations and drives the active-low stuff-error flag STF_E consumed by the error block.
// - Sits between the bit-timing/sample-point logic and the frame decoder. Delivers destuffed bits plus a destuffed-bit count.

---
 rtl/can_pkg.sv | 15 +
 rtl/can_bit_destuffer.sv | 124 ++++++++++++
 tb/tb_can_bit_destuffer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/can_pkg.sv
// Shared CAN definitions: destuffer state encoding and bus-level constants.
package can_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    EXPECT_STUFF,
    ERR
  } destuff_state_t;

  localparam logic RECESSIVE     = 1'b1;
  localparam logic DOMINANT      = 1'b0;
  localparam int   STUFF_LEN_DEF = 5;

endpackage

// File: rtl/can_bit_destuffer.sv
// Removes CAN stuff bits from the sampled RX stream, flags stuff violations
// (active-low) and counts destuffed bits delivered since start of frame.
module can_bit_destuffer
  import can_pkg::*;
#(
  parameter int STUFF_LEN = STUFF_LEN_DEF,
  parameter int CNT_W     = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sp,
  input  logic             rx_bit,
  input  logic             stuff_en,
  output logic             data_valid,
  output logic             data_bit,
  output logic             stuff_drop,
  output logic             stf_e_n,
  output logic [CNT_W-1:0] dbit_cnt
);

  localparam int RUN_W = $clog2(STUFF_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUFF_LEN);

  destuff_state_t   state_q, state_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic             last_bit_q, last_bit_d;
  logic             data_valid_q, data_valid_d;
  logic             data_bit_q, data_bit_d;
  logic             stuff_drop_q, stuff_drop_d;
  logic             stf_e_n_q, stf_e_n_d;
  logic [CNT_W-1:0] dbit_cnt_q, dbit_cnt_d;

  // Leaving the stuffed region takes priority over any sampled bit.
  always_comb begin
    state_d      = state_q;
    run_cnt_d    = run_cnt_q;
    last_bit_d   = last_bit_q;
    data_valid_d = 1'b0;
    data_bit_d   = data_bit_q;
    stuff_drop_d = 1'b0;
    stf_e_n_d    = stf_e_n_q;
    dbit_cnt_d   = dbit_cnt_q;

    if (state_q != IDLE && !stuff_en) begin
      state_d    = IDLE;
      run_cnt_d  = '0;
      last_bit_d = RECESSIVE;
      stf_e_n_d  = 1'b1;
    end else if (sp) begin
      case (state_q)
        IDLE: begin
          if (stuff_en) begin
            last_bit_d   = rx_bit;
            run_cnt_d    = RUN_ONE;
            dbit_cnt_d   = CNT_W'(1);
            data_valid_d = 1'b1;
            data_bit_d   = rx_bit;
            state_d      = (RUN_ONE == RUN_MAX) ? EXPECT_STUFF : COUNT;
          end
        end
        COUNT: begin
          data_valid_d = 1'b1;
          data_bit_d   = rx_bit;
          if (dbit_cnt_q != '1) begin
            dbit_cnt_d = dbit_cnt_q + CNT_W'(1);
          end
          if (rx_bit == last_bit_q) begin
            run_cnt_d = (run_cnt_q >= RUN_MAX) ? RUN_MAX : run_cnt_q + RUN_ONE;
          end else begin
            run_cnt_d  = RUN_ONE;
            last_bit_d = rx_bit;
          end
          if (run_cnt_d == RUN_MAX) begin
            state_d = EXPECT_STUFF;
          end
        end
        EXPECT_STUFF: begin
          // The stuff bit itself opens the next run of equal bits.
          if (rx_bit != last_bit_q) begin
            stuff_drop_d = 1'b1;
            last_bit_d   = rx_bit;
            run_cnt_d    = RUN_ONE;
            state_d      = (RUN_ONE == RUN_MAX) ? EXPECT_STUFF : COUNT;
          end else begin
            stf_e_n_d = 1'b0;
            state_d   = ERR;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      run_cnt_q    <= '0;
      last_bit_q   <= RECESSIVE;
      data_valid_q <= 1'b0;
      data_bit_q   <= RECESSIVE;
      stuff_drop_q <= 1'b0;
      stf_e_n_q    <= 1'b1;
      dbit_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      run_cnt_q    <= run_cnt_d;
      last_bit_q   <= last_bit_d;
      data_valid_q <= data_valid_d;
      data_bit_q   <= data_bit_d;
      stuff_drop_q <= stuff_drop_d;
      stf_e_n_q    <= stf_e_n_d;
      dbit_cnt_q   <= dbit_cnt_d;
    end
  end

  assign data_valid = data_valid_q;
  assign data_bit   = data_bit_q;
  assign stuff_drop = stuff_drop_q;
  assign stf_e_n    = stf_e_n_q;
  assign dbit_cnt   = dbit_cnt_q;

endmodule

// File: tb/tb_can_bit_destuffer.sv
// Bench for can_bit_destuffer: directed scenarios plus a random stream, all
// checked against a model that applies the bit-stuffing rule to raw history.
module tb_can_bit_destuffer;

  localparam int STUFF_LEN = 5;
  localparam int CNT_W     = 7;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             sp;
  logic             rx_bit;
  logic             stuff_en;
  logic             data_valid;
  logic             data_bit;
  logic             stuff_drop;
  logic             stf_e_n;
  logic [CNT_W-1:0] dbit_cnt;

  int nAsserts = 0;
  int nFail    = 0;

  // Reference model: raw (undestuffed) history of the current frame.
  bit mActive;
  bit mErr;
  bit mHist[$];
  int mCnt;
  bit mDbit;
  bit mDv;
  bit mDrop;

  can_bit_destuffer #(.STUFF_LEN(STUFF_LEN), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .sp         (sp),
    .rx_bit     (rx_bit),
    .stuff_en   (stuff_en),
    .data_valid (data_valid),
    .data_bit   (data_bit),
    .stuff_drop (stuff_drop),
    .stf_e_n    (stf_e_n),
    .dbit_cnt   (dbit_cnt)
  );

  always #5 clk = ~clk;

  function automatic int trailingRun();
    int n = 0;
    for (int i = mHist.size() - 1; i >= 0; i--) begin
      if (mHist[i] != mHist[mHist.size() - 1]) break;
      n++;
    end
    return n;
  endfunction

  function automatic bit expectStuff();
    return mActive && !mErr && mHist.size() > 0 && trailingRun() >= STUFF_LEN;
  endfunction

  task automatic modelReset();
    mActive = 0;
    mErr    = 0;
    mHist.delete();
    mCnt    = 0;
    mDbit   = 1;
    mDv     = 0;
    mDrop   = 0;
  endtask

  task automatic modelStep(input bit s, input bit r, input bit e);
    mDv   = 0;
    mDrop = 0;
    if (mActive && !e) begin
      mActive = 0;
      mErr    = 0;
      mHist.delete();
    end else if (!mActive) begin
      if (s && e) begin
        mActive = 1;
        mHist.delete();
        mHist.push_back(r);
        mCnt = 1;
        mDv  = 1;
        mDbit = r;
      end
    end else if (s && !mErr) begin
      if (expectStuff()) begin
        if (r != mHist[mHist.size() - 1]) begin
          mDrop = 1;
          mHist.push_back(r);
        end else begin
          mErr = 1;
        end
      end else begin
        mHist.push_back(r);
        mDv   = 1;
        mDbit = r;
        if (mCnt < CNT_MAX) mCnt++;
      end
      if (mHist.size() > STUFF_LEN) void'(mHist.pop_front());
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".data_valid"}, 32'(data_valid), 32'(mDv));
    checkOutput({tag, ".data_bit"},   32'(data_bit),   32'(mDbit));
    checkOutput({tag, ".stuff_drop"}, 32'(stuff_drop), 32'(mDrop));
    checkOutput({tag, ".stf_e_n"},    32'(stf_e_n),    32'(!mErr));
    checkOutput({tag, ".dbit_cnt"},   32'(dbit_cnt),   32'(mCnt));
  endtask

  task automatic applyStimulus(input string tag, input bit s, input bit r, input bit e);
    sp       = s;
    rx_bit   = r;
    stuff_en = e;
    @(posedge clk);
    #1;
    modelStep(s, r, e);
    checkAll(tag);
  endtask

  task automatic sendBits(input string tag, input bit bits[$]);
    foreach (bits[i]) applyStimulus(tag, 1'b1, bits[i], 1'b1);
  endtask

  initial begin
    bit s;
    bit r;
    bit e;
    bit prev;

    sp = 0; rx_bit = 1; stuff_en = 0; reset = 1;
    modelReset();
    #3;
    checkAll("reset");
    @(posedge clk); #2;
    reset = 0;
    applyStimulus("idle", 1'b0, 1'b1, 1'b0);

    // T1: five dominant bits, stuff, then data
    sendBits("T1", '{0, 0, 0, 0, 0});
    applyStimulus("T1", 1'b1, 1'b1, 1'b1);
    checkOutput("T1.drop6", 32'(stuff_drop), 32'd1);
    applyStimulus("T1", 1'b1, 1'b1, 1'b1);
    checkOutput("T1.cnt", 32'(dbit_cnt), 32'd6);
    checkOutput("T1.err", 32'(stf_e_n), 32'd1);
    applyStimulus("T1.exit", 1'b0, 1'b1, 1'b0);

    // T2: six equal bits is a stuff violation
    sendBits("T2", '{0, 0, 0, 0, 0, 0});
    checkOutput("T2.err", 32'(stf_e_n), 32'd0);
    applyStimulus("T2.hold", 1'b1, 1'b1, 1'b1);
    applyStimulus("T2.hold", 1'b0, 1'b0, 1'b1);
    checkOutput("T2.held", 32'(stf_e_n), 32'd0);
    applyStimulus("T2.exit", 1'b0, 1'b0, 1'b0);
    checkOutput("T2.clear", 32'(stf_e_n), 32'd1);

    // T3: stuff bit counts toward the following run
    sendBits("T3", '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1});
    checkOutput("T3.drop11", 32'(stuff_drop), 32'd1);
    checkOutput("T3.cnt", 32'(dbit_cnt), 32'd9);
    applyStimulus("T3.exit", 1'b0, 1'b1, 1'b0);

    // T4: leaving the stuffed region with a stuff bit pending
    sendBits("T4", '{0, 0, 0, 0, 0});
    applyStimulus("T4.exit", 1'b0, 1'b0, 1'b0);
    checkOutput("T4.noerr", 32'(stf_e_n), 32'd1);
    applyStimulus("T4.idle", 1'b1, 1'b0, 1'b0);
    checkOutput("T4.nodv", 32'(data_valid), 32'd0);
    checkOutput("T4.nodrop", 32'(stuff_drop), 32'd0);

    // T5: asynchronous reset mid-run, then SOF with stuff_en still high
    sendBits("T5", '{1, 0, 0, 0, 0});
    sp = 0;
    #2;
    reset = 1;
    #1;
    modelReset();
    checkAll("T5.async");
    @(posedge clk); #2;
    reset = 0;
    applyStimulus("T5.sof", 1'b1, 1'b0, 1'b1);
    checkOutput("T5.cnt", 32'(dbit_cnt), 32'd1);
    applyStimulus("T5.exit", 1'b0, 1'b0, 1'b0);

    // T6: alternating bits saturate the counter without stuffing
    for (int i = 0; i < 200; i++) applyStimulus("T6", 1'b1, 1'(i % 2), 1'b1);
    checkOutput("T6.sat", 32'(dbit_cnt), 32'(CNT_MAX));
    checkOutput("T6.err", 32'(stf_e_n), 32'd1);
    applyStimulus("T6.exit", 1'b0, 1'b0, 1'b0);

    // Random stream biased toward long runs so stuffing and violations occur
    e = 1;
    prev = 1;
    for (int i = 0; i < 1500; i++) begin
      s = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) < 2) e = ~e;
      if (expectStuff()) r = ($urandom_range(0, 9) < 8) ? ~prev : prev;
      else               r = ($urandom_range(0, 9) < 7) ? prev : ~prev;
      if (s) prev = r;
      applyStimulus("rand", s, r, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
